// File: rtl/cdb_arbiter_if.sv
// Writeback request / common-data-bus signal bundle between the FU result stages and the CDB.
// master = requester side (FUs plus CDB consumers), slave = the arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CDB_WIDTH = 2,
    parameter int unsigned ROB_IDX   = 5,
    parameter int unsigned PRF_IDX   = 6
) ();
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*ROB_IDX-1:0]   req_rob_id;
    logic [NUM_REQ*PRF_IDX-1:0]   req_rd_phy;
    logic [NUM_REQ*32-1:0]        req_rd_value;

    logic [CDB_WIDTH-1:0]         cdb_valid;
    logic [CDB_WIDTH*ROB_IDX-1:0] cdb_rob_id;
    logic [CDB_WIDTH*PRF_IDX-1:0] cdb_rd_phy;
    logic [CDB_WIDTH*32-1:0]      cdb_rd_value;

    modport master (
        output req_valid, req_rob_id, req_rd_phy, req_rd_value,
        input  req_ready, cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_value
    );

    modport slave (
        input  req_valid, req_rob_id, req_rd_phy, req_rd_value,
        output req_ready, cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_value
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to CDB_WIDTH of NUM_REQ writeback requesters per cycle onto
// registered CDB slots, with a saturating count of oversubscribed cycles.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CDB_WIDTH = 2,
    parameter int unsigned ROB_IDX   = 5,
    parameter int unsigned PRF_IDX   = 6,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    cdb_arbiter_if.slave     bus_io,
    output logic [CNT_W-1:0] conflict_cnt_o
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [CDB_WIDTH-1:0]         cdb_valid_q, cdb_valid_d;
    logic [CDB_WIDTH*ROB_IDX-1:0] cdb_rob_q, cdb_rob_d;
    logic [CDB_WIDTH*PRF_IDX-1:0] cdb_phy_q, cdb_phy_d;
    logic [CDB_WIDTH*32-1:0]      cdb_val_q, cdb_val_d;
    logic [CNT_W-1:0]             conflict_q, conflict_d;
    logic [NUM_REQ-1:0]           grant;

    int unsigned idx;
    int unsigned slot;
    int unsigned last;
    int unsigned pop;

    // Walk requesters from rr_ptr in wrap order; the j-th winner lands in slot j.
    always_comb begin
        grant       = '0;
        cdb_valid_d = '0;
        cdb_rob_d   = cdb_rob_q;
        cdb_phy_d   = cdb_phy_q;
        cdb_val_d   = cdb_val_q;
        rr_ptr_d    = rr_ptr_q;
        idx         = 0;
        slot        = 0;
        last        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!rst && !flush_i && bus_io.req_valid[idx] && (slot < CDB_WIDTH)) begin
                grant[idx]                           = 1'b1;
                cdb_valid_d[slot]                    = 1'b1;
                cdb_rob_d[slot*ROB_IDX +: ROB_IDX]   = bus_io.req_rob_id[idx*ROB_IDX +: ROB_IDX];
                cdb_phy_d[slot*PRF_IDX +: PRF_IDX]   = bus_io.req_rd_phy[idx*PRF_IDX +: PRF_IDX];
                cdb_val_d[slot*32 +: 32]             = bus_io.req_rd_value[idx*32 +: 32];
                last                                 = idx;
                slot                                 = slot + 1;
            end
        end

        if (flush_i) begin
            rr_ptr_d = '0;
        end else if (slot != 0) begin
            rr_ptr_d = (last + 1 >= NUM_REQ) ? '0 : PTR_W'(last + 1);
        end
    end

    always_comb begin
        pop = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pop = pop + 32'(bus_io.req_valid[i]);
        end
        conflict_d = conflict_q;
        if (!flush_i && (pop > CDB_WIDTH) && (conflict_q != '1)) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_rob_q   <= '0;
            cdb_phy_q   <= '0;
            cdb_val_q   <= '0;
            conflict_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_phy_q   <= cdb_phy_d;
            cdb_val_q   <= cdb_val_d;
            conflict_q  <= conflict_d;
        end
    end

    assign bus_io.req_ready    = grant;
    assign bus_io.cdb_valid    = cdb_valid_q;
    assign bus_io.cdb_rob_id   = cdb_rob_q;
    assign bus_io.cdb_rd_phy   = cdb_phy_q;
    assign bus_io.cdb_rd_value = cdb_val_q;
    assign conflict_cnt_o      = conflict_q;
endmodule
